// File: rtl/operand_fetch.sv
// operand_fetch: register-bank read initiator with busy scoreboard and RAW stall
module operand_fetch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rsd,
  input  logic             in_we,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [WIDTH-1:0] rf_rs1_data,
  input  logic [WIDTH-1:0] rf_rs2_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rs1_val,
  output logic [WIDTH-1:0] out_rs2_val,
  output logic [4:0]       out_rsd,
  output logic             out_we
);
  typedef enum logic [1:0] {IDLE, CHK, CAPT, HOLD} state_t;
  state_t state, state_d;
  logic [4:0] rs1, rs2, rsd;
  logic we, hazard, fire;
  logic [31:0] busy, busy_d, clr, set;
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;
  assign in_ready = state == IDLE;
  // a writeback landing on the CHK exit edge is committed before the bank samples, so it clears the hazard
  always_comb begin
    hazard = (rs1 != 0 && busy[rs1] && !(wb_en && wb_rd == rs1)) ||
             (rs2 != 0 && busy[rs2] && !(wb_en && wb_rd == rs2));
    fire = out_valid && out_ready;
    clr = (wb_en && wb_rd != 0) ? 32'd1 << wb_rd : 32'd0;
    set = (fire && we && rsd != 0) ? 32'd1 << rsd : 32'd0;
    busy_d = (busy & ~clr) | set;
    state_d = state;
    unique case (state)
      IDLE: state_d = in_valid ? CHK : IDLE;
      CHK:  state_d = hazard ? CHK : CAPT;
      CAPT: state_d = HOLD;
      HOLD: state_d = out_ready ? IDLE : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rs1 <= '0;
      rs2 <= '0;
      rsd <= '0;
      we <= 1'b0;
      busy <= '0;
      out_valid <= 1'b0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rsd <= '0;
      out_we <= 1'b0;
    end else begin
      state <= state_d;
      busy <= busy_d;
      if (state == IDLE && in_valid) begin
        rs1 <= in_rs1;
        rs2 <= in_rs2;
        rsd <= in_rsd;
        we <= in_we;
      end
      if (state == CAPT) begin
        out_rs1_val <= rs1 == 0 ? '0 : rf_rs1_data;
        out_rs2_val <= rs2 == 0 ? '0 : rf_rs2_data;
        out_rsd <= rsd;
        out_we <= we;
        out_valid <= 1'b1;
      end else if (fire) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized and directed checks against a scoreboard/bank model
module tb_operand_fetch;
  localparam int WIDTH = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, in_we, wb_en, out_valid, out_ready, out_we;
  logic [4:0] in_rs1, in_rs2, in_rsd, rf_rs1, rf_rs2, wb_rd, out_rsd;
  logic [WIDTH-1:0] rf_rs1_data, rf_rs2_data, out_rs1_val, out_rs2_val, wb_data;
  logic [WIDTH-1:0] mem [32];
  logic force_ones;
  logic [31:0] mbusy;
  int n_checks, n_fail;

  operand_fetch #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rsd(in_rsd), .in_we(in_we),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rsd(out_rsd), .out_we(out_we)
  );

  // register bank: write-before-read, one-cycle synchronous read
  always @(posedge clk) begin
    if (wb_en && wb_rd != 0) mem[wb_rd] <= wb_data;
    rf_rs1_data <= force_ones ? '1 : rf_rs1 == 0 ? '0 : (wb_en && wb_rd == rf_rs1) ? wb_data : mem[rf_rs1];
    rf_rs2_data <= force_ones ? '1 : rf_rs2 == 0 ? '0 : (wb_en && wb_rd == rf_rs2) ? wb_data : mem[rf_rs2];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic w);
    in_valid = 1'b1; in_rs1 = a; in_rs2 = b; in_rsd = d; in_we = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] r, input logic [WIDTH-1:0] v);
    wb_en = 1'b1; wb_rd = r; wb_data = v;
    tick();
    wb_en = 1'b0;
    if (r != 0) mbusy[r] = 1'b0;
  endtask

  task automatic handshake(input logic wb, input logic [4:0] r, input logic [WIDTH-1:0] v,
                           input logic [4:0] d, input logic w);
    out_ready = 1'b1; wb_en = wb; wb_rd = r; wb_data = v;
    tick();
    out_ready = 1'b0; wb_en = 1'b0;
    if (wb && r != 0) mbusy[r] = 1'b0;
    if (w && d != 0) mbusy[d] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if ({rf_rs1, rf_rs2, out_rsd, out_we} !== 16'd0) begin n_fail++; $display("FAIL reset_fields got %h %h %h %b want 0", rf_rs1, rf_rs2, out_rsd, out_we); end
    n_checks++; if ({out_rs1_val, out_rs2_val} !== '0) begin n_fail++; $display("FAIL reset_vals got %h %h want 0", out_rs1_val, out_rs2_val); end
    n_checks++; if (dut.busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", dut.busy); end
  endtask

  task automatic test_basic;
    load(3, 32'h11);
    load(4, 32'h22);
    send(3, 4, 5, 1'b1);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_chk got ready=%b valid=%b want 0 0", in_ready, out_valid); end
    n_checks++; if (rf_rs1 !== 5'd3 || rf_rs2 !== 5'd4) begin n_fail++; $display("FAIL basic_addr got %0d %0d want 3 4", rf_rs1, rf_rs2); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_capt_valid got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got valid=%b want 1", out_valid); end
    n_checks++; if (out_rs1_val !== 32'h11 || out_rs2_val !== 32'h22) begin n_fail++; $display("FAIL basic_vals got %h %h want 11 22", out_rs1_val, out_rs2_val); end
    n_checks++; if (out_rsd !== 5'd5 || out_we !== 1'b1) begin n_fail++; $display("FAIL basic_rsd got %0d %b want 5 1", out_rsd, out_we); end
    handshake(1'b0, 0, 0, 5, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    n_checks++; if (dut.busy !== mbusy) begin n_fail++; $display("FAIL basic_busy got %h want %h", dut.busy, mbusy); end
  endtask

  task automatic test_raw_stall;
    send(5, 0, 6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall cyc %0d got ready=%b valid=%b want 0 0", i, in_ready, out_valid); end
    end
    wb_en = 1'b1; wb_rd = 5; wb_data = 32'hABCD;
    tick();
    wb_en = 1'b0; mbusy[5] = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_release got valid=%b want 1", out_valid); end
    n_checks++; if (out_rs1_val !== 32'hABCD || out_rs2_val !== 32'd0) begin n_fail++; $display("FAIL raw_vals got %h %h want abcd 0", out_rs1_val, out_rs2_val); end
    n_checks++; if (dut.busy !== mbusy) begin n_fail++; $display("FAIL raw_busy got %h want %h", dut.busy, mbusy); end
    handshake(1'b0, 0, 0, 6, 1'b0);
  endtask

  task automatic test_x0;
    force_ones = 1'b1;
    send(0, 0, 0, 1'b1);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1 || out_rs1_val !== '0 || out_rs2_val !== '0) begin n_fail++; $display("FAIL x0_vals got v=%b %h %h want 1 0 0", out_valid, out_rs1_val, out_rs2_val); end
    handshake(1'b0, 0, 0, 0, 1'b1);
    force_ones = 1'b0;
    n_checks++; if (dut.busy !== mbusy) begin n_fail++; $display("FAIL x0_busy got %h want %h", dut.busy, mbusy); end
  endtask

  task automatic test_hold;
    load(1, 32'hCAFE0001);
    load(2, 32'hBEEF0002);
    send(1, 2, 8, 1'b0);
    tick(); tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs1 = 9; in_rs2 = 10; in_rsd = 11; in_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rs1_val !== 32'hCAFE0001 || out_rs2_val !== 32'hBEEF0002 || out_rsd !== 5'd8 || rf_rs1 !== 5'd1)
        begin n_fail++; $display("FAIL hold cyc %0d got v=%b r=%b %h %h rsd=%0d rf=%0d", i, out_valid, in_ready, out_rs1_val, out_rs2_val, out_rsd, rf_rs1); end
    end
    in_valid = 1'b0;
    handshake(1'b0, 0, 0, 8, 1'b0);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got ready=%b valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_set_wins;
    send(1, 2, 7, 1'b1);
    tick(); tick();
    handshake(1'b1, 7, 32'h77, 7, 1'b1);
    n_checks++; if (dut.busy[7] !== 1'b1 || dut.busy !== mbusy) begin n_fail++; $display("FAIL set_wins got %h want %h", dut.busy, mbusy); end
    load(7, 32'h77);
  endtask

  task automatic test_reset_mid;
    send(1, 2, 9, 1'b1);
    tick(); tick();
    handshake(1'b0, 0, 0, 9, 1'b1);
    send(9, 0, 3, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mbusy = '0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid got ready=%b valid=%b want 1 0", in_ready, out_valid); end
    n_checks++; if (dut.busy !== 32'd0 || rf_rs1 !== 5'd0) begin n_fail++; $display("FAIL rst_mid_state got busy=%h rf=%0d want 0 0", dut.busy, rf_rs1); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic [4:0] a, b, d, r;
      logic w, doit, haz;
      int cyc;
      a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1));
      send(a, b, d, w);
      cyc = 0;
      haz = 1'b1;
      while (haz && cyc < 60) begin
        if (cyc >= 3 && a != 0 && mbusy[a]) begin doit = 1'b1; r = a; end
        else if (cyc >= 3 && b != 0 && mbusy[b]) begin doit = 1'b1; r = b; end
        else begin doit = $urandom_range(0, 2) == 0; r = 5'($urandom_range(0, 7)); end
        haz = (a != 0 && mbusy[a] && !(doit && r == a)) || (b != 0 && mbusy[b] && !(doit && r == b));
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_chk k=%0d cyc=%0d got ready=%b valid=%b", k, cyc, in_ready, out_valid); end
        wb_en = doit; wb_rd = r; wb_data = $urandom;
        tick();
        wb_en = 1'b0;
        if (doit && r != 0) mbusy[r] = 1'b0;
        cyc++;
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_capt k=%0d got valid=%b want 0", k, out_valid); end
      tick();
      for (int h = 0; h <= int'($urandom_range(0, 3)); h++) begin
        if (h > 0) tick();
        n_checks++; if (out_valid !== 1'b1 || out_rs1_val !== (a == 0 ? '0 : mem[a]) || out_rs2_val !== (b == 0 ? '0 : mem[b]) || out_rsd !== d || out_we !== w)
          begin n_fail++; $display("FAIL rnd_out k=%0d got v=%b %h %h %0d %b want %h %h %0d %b", k, out_valid, out_rs1_val, out_rs2_val, out_rsd, out_we,
                                  a == 0 ? '0 : mem[a], b == 0 ? '0 : mem[b], d, w); end
      end
      doit = $urandom_range(0, 3) == 0;
      handshake(doit, 5'($urandom_range(0, 7)), $urandom, d, w);
      n_checks++; if (dut.busy !== mbusy) begin n_fail++; $display("FAIL rnd_busy k=%0d got %h want %h", k, dut.busy, mbusy); end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mbusy = '0; force_ones = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_rs1 = 0; in_rs2 = 0; in_rsd = 0; in_we = 1'b0;
    wb_en = 1'b0; wb_rd = 0; wb_data = '0; out_ready = 1'b0;
    test_reset();
    for (int i = 1; i < 32; i++) load(5'(i), $urandom);
    test_basic();
    test_raw_stall();
    test_x0();
    test_hold();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Initiator side of the register bank read/write interface.
- Accepts a decoded instruction (source/destination register indices) over a valid/ready handshake.
- Drives the bank's rs1/rs2 read addresses and absorbs the bank's one-cycle synchronous read latency.
- Holds a 32-entry busy scoreboard fed by the writeback bus, stalls read-after-write hazards, and presents both operands to execute over a second valid/ready handshake.

Parameters:
WIDTH, 32, data width of register values and operands

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  decoded instruction available
in_ready  output  1  block can accept an instruction
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_rsd  input  5  destination register index
in_we  input  1  instruction writes in_rsd
rf_rs1  output  5  read address 1 to register bank
rf_rs2  output  5  read address 2 to register bank
rf_rs1_data  input  WIDTH  bank read data 1, valid the cycle after rf_rs1 is sampled
rf_rs2_data  input  WIDTH  bank read data 2, valid the cycle after rf_rs2 is sampled
wb_en  input  1  writeback to bank this cycle (same signal as bank write enable)
wb_rd  input  5  writeback destination index
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts operands
out_rs1_val  output  WIDTH  operand 1
out_rs2_val  output  WIDTH  operand 2
out_rsd  output  5  destination index passed through
out_we  output  1  write flag passed through

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, busy[31:0]=0.
  - out_valid=0; out_rs1_val, out_rs2_val, out_rsd, out_we = 0.
  - Latched fields are cleared to 0, so rf_rs1 and rf_rs2 are 0.
  - Reset mid-operation discards any in-flight instruction; no busy bit survives.
- States:
  - IDLE: in_ready=1. On in_valid, latch rs1/rs2/rsd/we and go to CHK.
  - CHK: rf_rs1/rf_rs2 are driven from the latched fields, and are driven from those fields in every state.
    - hazard = (rs1!=0 & busy[rs1] & !(wb_en & wb_rd==rs1)) | the same term for rs2.
    - If hazard, stay in CHK. Otherwise go to CAPT; the bank samples the addresses at this edge.
  - CAPT:
    - out_rs1_val <= (rs1==0) ? 0 : rf_rs1_data, and likewise for rs2.
    - out_rsd <= rsd, out_we <= we, out_valid <= 1; go to HOLD.
  - HOLD: outputs stable while out_valid & !out_ready. On out_ready: out_valid <= 0, go to IDLE.
  - in_ready=0 in CHK, CAPT and HOLD. There is no skid; at most one instruction is in flight.
- Latency: in_valid accepted at edge E0 gives CHK, then CAPT, then out_valid high after edge E0+2 when there is no hazard.
- Writeback coincident with the CHK exit edge: the bank commits the write before its read sample, so the new value is returned. This is why a same-cycle wb clears the hazard.
- Scoreboard:
  - Set busy[rsd] on the out handshake (out_valid & out_ready) when we=1 and rsd!=0.
  - Clear busy[wb_rd] when wb_en=1 and wb_rd!=0.
  - Set and clear on the same index in the same cycle: set wins, because the newer producer owns the register.
- Register x0 is never busy, always reads 0, and wb to index 0 is ignored.
- An instruction whose rs1 or rs2 equals its own rsd checks only its own sources. Its busy bit is set only at issue.

Test Plan:
- Reset, then in rs1=3 rs2=4 rsd=5 we=1, bank holds x3=0x11, x4=0x22 -> out_valid 2 cycles after accept, out_rs1_val=0x11, out_rs2_val=0x22, out_rsd=5; after handshake busy[5]=1.
- Issue writer to x5, then a reader of x5 with no wb -> stays in CHK, in_ready=0; wb_en=1 wb_rd=5 wb_data=0xABCD -> next cycle CAPT, out_rs1_val=0xABCD, busy[5]=0.
- rs1=0 rs2=0, bank forced to return 0xFFFFFFFF -> out_rs1_val=out_rs2_val=0; an instruction with we=1 rsd=0 issued -> busy stays 0.
- Hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
- Issue of a writer to x7 on the same cycle as wb_en wb_rd=7 -> busy[7]=1 afterwards.
- Assert rst while in CHK with busy[9]=1 -> next cycle IDLE, out_valid=0, busy=0, in_ready=1.
